// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control decoder with mult/div sequencing (option: ALU_CTRL_ILLEGAL_TRAP_EN)
module alu_control_seq #(
   parameter int CTRL_W  = 4,
   parameter int FUNCT_W = 6,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [1:0]         i_ALUOp,
   input  logic [FUNCT_W-1:0] i_funct,
   input  logic               i_flush,
   output logic               o_valid,
   output logic [CTRL_W-1:0]  o_ALUcontrol,
   output logic               o_multi,
   output logic               o_illegal
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

   localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
   localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(4'b0011);
   localparam logic [CTRL_W-1:0] C_MUL  = CTRL_W'(4'b0100);
   localparam logic [CTRL_W-1:0] C_DIV  = CTRL_W'(4'b0101);
   localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0110);
   localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b0111);
   localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4'b1000);
   localparam logic [CTRL_W-1:0] C_NOR  = CTRL_W'(4'b1100);

   typedef enum logic [0:0] {IDLE, BUSY} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [CTRL_W-1:0]  ctrl, ctrl_n;
   logic               valid, valid_n;
   logic [CTRL_W-1:0]  dec_ctrl;
   logic               dec_multi;
   logic [CNT_W-1:0]   dec_load;
   logic               accept;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic               dec_known;
   logic               illegal, illegal_n;
`endif

   // Decode the ALUOp class and R-type funct into a control code and multi-cycle flag.
   always_comb begin
      dec_ctrl  = C_ADD;
      dec_multi = 1'b0;
      dec_load  = MUL_LOAD;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      dec_known = 1'b1;
`endif
      case (i_ALUOp)
         2'b00: dec_ctrl = C_ADD;
         2'b01: dec_ctrl = C_SUB;
         2'b11: dec_ctrl = C_AND;
         default: begin
            case (i_funct)
               FUNCT_W'(6'b100000), FUNCT_W'(6'b100001): dec_ctrl = C_ADD;
               FUNCT_W'(6'b100010), FUNCT_W'(6'b100011): dec_ctrl = C_SUB;
               FUNCT_W'(6'b100100): dec_ctrl = C_AND;
               FUNCT_W'(6'b100101): dec_ctrl = C_OR;
               FUNCT_W'(6'b100110): dec_ctrl = C_XOR;
               FUNCT_W'(6'b100111): dec_ctrl = C_NOR;
               FUNCT_W'(6'b101010): dec_ctrl = C_SLT;
               FUNCT_W'(6'b101011): dec_ctrl = C_SLTU;
               FUNCT_W'(6'b011000): begin
                  dec_ctrl  = C_MUL;
                  dec_multi = 1'b1;
                  dec_load  = MUL_LOAD;
               end
               FUNCT_W'(6'b011010): begin
                  dec_ctrl  = C_DIV;
                  dec_multi = 1'b1;
                  dec_load  = DIV_LOAD;
               end
               default: begin
                  dec_ctrl = C_ADD;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                  dec_known = 1'b0;
`endif
               end
            endcase
         end
      endcase
   end

   assign o_ready = (state == IDLE);
   assign o_multi = (state == BUSY);
   assign accept  = i_valid && o_ready && !i_flush;

   // Next-state logic: single-cycle ops pulse valid, mult/div park in BUSY until the count expires.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ctrl_n  = ctrl;
      valid_n = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal_n = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
               if (!dec_known) begin
                  valid_n   = 1'b1;
                  illegal_n = 1'b1;
               end else
`endif
               begin
                  ctrl_n = dec_ctrl;
                  if (dec_multi) begin
                     state_n = BUSY;
                     cnt_n   = dec_load;
                  end else begin
                     valid_n = 1'b1;
                  end
               end
            end
         end
         default: begin
            if (i_flush) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == '0) begin
               state_n = IDLE;
               valid_n = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
      endcase
   end

   // State and output registers; reset aborts any in-flight op without a result.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ctrl  <= C_ADD;
         valid <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ctrl  <= ctrl_n;
         valid <= valid_n;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
         illegal <= illegal_n;
`endif
      end
   end

   assign o_valid      = valid;
   assign o_ALUcontrol = ctrl;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   assign o_illegal    = illegal;
`else
   assign o_illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - scoreboard bench for alu_control_seq
module tb_alu_control_seq;

   logic       clk;
   logic       rst_n;
   logic       i_valid;
   logic       o_ready;
   logic [1:0] i_ALUOp;
   logic [5:0] i_funct;
   logic       i_flush;
   logic       o_valid;
   logic [3:0] o_ALUcontrol;
   logic       o_multi;
   logic       o_illegal;

   typedef struct {
      logic [3:0] ctrl;
      logic       ill;
      int         at;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   n_cmp;
   int   n_bad;

   alu_control_seq dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_ALUOp      (i_ALUOp),
      .i_funct      (i_funct),
      .i_flush      (i_flush),
      .o_valid      (o_valid),
      .o_ALUcontrol (o_ALUcontrol),
      .o_multi      (o_multi),
      .o_illegal    (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: value n is visible during the period after the n-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
      i_valid = v;
      i_ALUOp = op;
      i_funct = f;
   endtask

   task automatic push(input logic [3:0] c, input logic il, input int at);
      exp_t e;
      e.ctrl = c;
      e.ill  = il;
      e.at   = at;
      q.push_back(e);
   endtask

   // Monitor: every o_valid pulse must match the oldest expected result, in the expected cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got o_valid=1 ctrl=%0h expected no result (cycle %0d)", o_ALUcontrol, cyc);
            end else begin
               e = q.pop_front();
               chk("result_ctrl", int'(o_ALUcontrol), int'(e.ctrl));
               chk("result_illegal", int'(o_illegal), int'(e.ill));
               chk("result_cycle", cyc, e.at);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [5:0] tab_f[6]  = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100110, 6'b101010};
   logic [3:0] tab_c[6]  = '{4'b0010, 4'b0010, 4'b0110, 4'b0000, 4'b0011, 4'b0111};
   logic [1:0] tab_op[3] = '{2'b00, 2'b01, 2'b11};
   logic [3:0] tab_oc[3] = '{4'b0010, 4'b0110, 4'b0000};

   initial begin
      int c0;
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      i_flush = 1'b0;
      drive(1'b0, 2'b00, 6'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ctrl", int'(o_ALUcontrol), 4'b0010);
      chk("reset_ready", int'(o_ready), 1);
      chk("reset_valid", int'(o_valid), 0);
      chk("reset_multi", int'(o_multi), 0);
      chk("reset_illegal", int'(o_illegal), 0);

      // back-to-back sub, nor, sltu
      drive(1'b1, 2'b10, 6'b100010); push(4'b0110, 1'b0, cyc + 1);
      @(negedge clk);
      chk("b2b_ready1", int'(o_ready), 1);
      drive(1'b1, 2'b10, 6'b100111); push(4'b1100, 1'b0, cyc + 1);
      @(negedge clk);
      chk("b2b_ready2", int'(o_ready), 1);
      drive(1'b1, 2'b10, 6'b101011); push(4'b1000, 1'b0, cyc + 1);
      @(negedge clk);
      chk("b2b_ready3", int'(o_ready), 1);

      // other classes and R-type codes, back-to-back
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, tab_op[i], 6'b111111); push(tab_oc[i], 1'b0, cyc + 1);
         @(negedge clk);
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 2'b10, tab_f[i]); push(tab_c[i], 1'b0, cyc + 1);
         @(negedge clk);
      end
      drive(1'b0, 2'b00, 6'b0);
      @(negedge clk);

      // mult with an add held from the next cycle
      c0 = cyc;
      drive(1'b1, 2'b10, 6'b011000); push(4'b0100, 1'b0, c0 + 4);
      @(negedge clk);
      drive(1'b1, 2'b10, 6'b100000);
      for (int k = 1; k <= 3; k++) begin
         chk("mul_ctrl", int'(o_ALUcontrol), 4'b0100);
         chk("mul_ready", int'(o_ready), 0);
         chk("mul_multi", int'(o_multi), 1);
         @(negedge clk);
      end
      chk("mul_done_ready", int'(o_ready), 1);
      chk("mul_done_multi", int'(o_multi), 0);
      push(4'b0010, 1'b0, c0 + 5);
      @(negedge clk);
      drive(1'b0, 2'b00, 6'b0);
      @(negedge clk);

      // flush while idle suppresses the accept
      i_flush = 1'b1;
      drive(1'b1, 2'b10, 6'b100101);
      @(negedge clk);
      i_flush = 1'b0;
      drive(1'b0, 2'b00, 6'b0);
      @(negedge clk);
      chk("idle_flush_ctrl", int'(o_ALUcontrol), 4'b0010);

      // div flushed in cycle 3
      c0 = cyc;
      drive(1'b1, 2'b10, 6'b011010);
      @(negedge clk);
      drive(1'b0, 2'b00, 6'b0);
      chk("div_multi", int'(o_multi), 1);
      @(negedge clk);
      @(negedge clk);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      chk("flush_ready", int'(o_ready), 1);
      chk("flush_multi", int'(o_multi), 0);
      chk("flush_ctrl", int'(o_ALUcontrol), 4'b0101);
      while (cyc < c0 + 10) @(negedge clk);
      chk("flush_ctrl_hold", int'(o_ALUcontrol), 4'b0101);

      // div aborted by reset in cycle 2
      drive(1'b1, 2'b10, 6'b011010);
      @(negedge clk);
      drive(1'b0, 2'b00, 6'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_ctrl", int'(o_ALUcontrol), 4'b0010);
      chk("arst_ready", int'(o_ready), 1);
      chk("arst_multi", int'(o_multi), 0);
      chk("arst_valid", int'(o_valid), 0);
      #1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // unknown funct after an or
      drive(1'b1, 2'b10, 6'b100101); push(4'b0001, 1'b0, cyc + 1);
      @(negedge clk);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      drive(1'b1, 2'b10, 6'b111111); push(4'b0001, 1'b1, cyc + 1);
`else
      drive(1'b1, 2'b10, 6'b111111); push(4'b0010, 1'b0, cyc + 1);
`endif
      @(negedge clk);
      drive(1'b0, 2'b00, 6'b0);
      @(negedge clk);
      chk("illegal_clear", int'(o_illegal), 0);

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
